// File: rtl/wb_rm_decoupler_if.sv
// Pipelined Wishbone bus bundle used on both sides of the RM decoupler.
// The master modport drives the request; the slave modport returns the response.
interface wb_rm_decoupler_if #(
  parameter int unsigned ADDR_W = 28
);
  logic [ADDR_W-1:0] adr;
  logic [31:0]       dat_w;
  logic [3:0]        sel;
  logic              we;
  logic              cyc;
  logic              stb;
  logic [31:0]       dat_r;
  logic              ack;
  logic              err;
  logic              stall;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err, stall
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err, stall
  );
endinterface

// File: rtl/wb_rm_decoupler.sv
// Wishbone isolation stage between the crossbar and the VS0 RM slave port.
// Define WB_RM_DECOUPLER_TIMEOUT_EN to add the drain timeout, FLUSH state and drain_timeout flag.
module wb_rm_decoupler #(
  parameter int unsigned ADDR_W          = 28,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic rm_shutdown_req,
  input  logic rm_decouple,
  output logic rm_shutdown_ack,
  input  logic rm_irq_i,
  output logic rm_irq_o,
`ifdef WB_RM_DECOUPLER_TIMEOUT_EN
  output logic drain_timeout,
`endif
  wb_rm_decoupler_if.slave  wbs,
  wb_rm_decoupler_if.master wbm
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < 1 || TIMEOUT_CYCLES < 2 || $bits(wbs.adr) != ADDR_W) begin : g_param_check
    $error("wb_rm_decoupler: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
`ifdef WB_RM_DECOUPLER_TIMEOUT_EN
    S_FLUSH,
`endif
    S_ISOLATED
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [OUT_W-1:0] outst;
  logic [OUT_W-1:0] outst_nxt;
  logic             err_pend;

`ifdef WB_RM_DECOUPLER_TIMEOUT_EN
  localparam int unsigned TCNT_W = 16;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  logic [TCNT_W-1:0] tcnt;
`endif

  logic quiesce_c;
  logic full_c;
  logic stall_run_c;
  logic stb_run_c;
  logic inc_c;
  logic dec_c;

  assign quiesce_c   = rm_shutdown_req | rm_decouple;
  assign full_c      = (outst == OUT_MAX);
  assign stall_run_c = wbm.stall | full_c;
  assign stb_run_c   = wbs.stb & ~stall_run_c;
  assign inc_c       = stb_run_c & ~wbm.stall;
  assign dec_c       = wbm.ack | wbm.err;

  // Bus muxing, outstanding-count bookkeeping and next-state selection.
  always_comb begin
    wbm.adr     = '0;
    wbm.dat_w   = '0;
    wbm.sel     = '0;
    wbm.we      = 1'b0;
    wbm.cyc     = 1'b0;
    wbm.stb     = 1'b0;
    wbs.dat_r   = '0;
    wbs.ack     = 1'b0;
    wbs.err     = 1'b0;
    wbs.stall   = 1'b1;
    rm_irq_o    = 1'b0;
    state_nxt   = state;
    outst_nxt   = outst;

    unique case (state)
      S_RUN: begin
        wbm.adr   = wbs.adr;
        wbm.dat_w = wbs.dat_w;
        wbm.sel   = wbs.sel;
        wbm.we    = wbs.we;
        wbm.cyc   = wbs.cyc;
        wbm.stb   = stb_run_c;
        wbs.stall = stall_run_c;
        wbs.dat_r = wbm.dat_r;
        wbs.ack   = wbm.ack;
        wbs.err   = wbm.err;
        rm_irq_o  = rm_irq_i;
        // A dropped cycle aborts everything in flight on the RM side.
        if (!wbs.cyc) begin
          outst_nxt = '0;
        end else if (inc_c && !dec_c) begin
          outst_nxt = outst + OUT_W'(1);
        end else if (!inc_c && dec_c && outst != '0) begin
          outst_nxt = outst - OUT_W'(1);
        end
        if (quiesce_c) begin
          state_nxt = S_DRAIN;
        end
      end

      S_DRAIN: begin
        wbm.adr   = wbs.adr;
        wbm.dat_w = wbs.dat_w;
        wbm.sel   = wbs.sel;
        wbm.we    = wbs.we;
        wbm.cyc   = (outst != '0);
        rm_irq_o  = rm_irq_i;
        if (wbs.cyc) begin
          wbs.dat_r = wbm.dat_r;
          wbs.ack   = wbm.ack;
          wbs.err   = wbm.err;
        end
        if (dec_c && outst != '0) begin
          outst_nxt = outst - OUT_W'(1);
        end
        if (outst_nxt == '0) begin
          state_nxt = S_ISOLATED;
`ifdef WB_RM_DECOUPLER_TIMEOUT_EN
        end else if (tcnt == TCNT_LAST) begin
          state_nxt = S_FLUSH;
`endif
        end
      end

`ifdef WB_RM_DECOUPLER_TIMEOUT_EN
      // RM is presumed dead: retire one orphaned request per cycle with err.
      S_FLUSH: begin
        wbs.err = wbs.cyc & (outst != '0);
        if (outst != '0) begin
          outst_nxt = outst - OUT_W'(1);
        end
        if (outst_nxt == '0) begin
          state_nxt = S_ISOLATED;
        end
      end
`endif

      S_ISOLATED: begin
        wbs.stall = 1'b0;
        wbs.err   = err_pend;
        outst_nxt = '0;
        if (!quiesce_c && !wbs.cyc && !err_pend) begin
          state_nxt = S_RUN;
        end
      end

      default: begin
        state_nxt = S_RUN;
        outst_nxt = '0;
      end
    endcase

    // Abandon RM-side transactions while reset is held.
    if (rst) begin
      wbm.cyc = 1'b0;
      wbm.stb = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_RUN;
      outst           <= '0;
      err_pend        <= 1'b0;
      rm_shutdown_ack <= 1'b0;
`ifdef WB_RM_DECOUPLER_TIMEOUT_EN
      tcnt            <= '0;
      drain_timeout   <= 1'b0;
`endif
    end else begin
      state           <= state_nxt;
      outst           <= outst_nxt;
      err_pend        <= (state == S_ISOLATED) & wbs.cyc & wbs.stb;
      rm_shutdown_ack <= rm_shutdown_req & (state_nxt == S_ISOLATED);
`ifdef WB_RM_DECOUPLER_TIMEOUT_EN
      // Held at zero outside DRAIN, so every DRAIN entry starts from zero.
      if (state == S_DRAIN) begin
        tcnt <= tcnt + TCNT_W'(1);
      end else begin
        tcnt <= '0;
      end
      if (state_nxt == S_FLUSH && state != S_FLUSH) begin
        drain_timeout <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_wb_rm_decoupler.sv
// Self-checking bench for wb_rm_decoupler: behavioural RM slave, scoreboarded upstream master.
// Timeout scenarios are exercised when WB_RM_DECOUPLER_TIMEOUT_EN is defined.
module tb_wb_rm_decoupler;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned MAXO   = 4;
  localparam int unsigned TMO    = 16;

  logic clk = 1'b0;
  logic rst;
  logic rm_shutdown_req;
  logic rm_decouple;
  logic rm_shutdown_ack;
  logic rm_irq_i;
  logic rm_irq_o;
`ifdef WB_RM_DECOUPLER_TIMEOUT_EN
  logic drain_timeout;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  wb_rm_decoupler_if #(.ADDR_W(ADDR_W)) wbs ();
  wb_rm_decoupler_if #(.ADDR_W(ADDR_W)) wbm ();

  wb_rm_decoupler #(
    .ADDR_W(ADDR_W),
    .MAX_OUTSTANDING(MAXO),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rm_shutdown_req(rm_shutdown_req),
    .rm_decouple(rm_decouple),
    .rm_shutdown_ack(rm_shutdown_ack),
    .rm_irq_i(rm_irq_i),
    .rm_irq_o(rm_irq_o),
`ifdef WB_RM_DECOUPLER_TIMEOUT_EN
    .drain_timeout(drain_timeout),
`endif
    .wbs(wbs),
    .wbm(wbm)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rm_data(input logic [ADDR_W-1:0] a);
    return 32'(a) ^ 32'hA5C3_0F96 ^ {a[3:0], 28'h0};
  endfunction

  // Behavioural RM slave: in-order responses, each ack rm_lat+1 cycles after acceptance.
  typedef struct {
    logic [ADDR_W-1:0] adr;
    int unsigned       due;
  } rm_req_t;

  rm_req_t     rm_q[$];
  int unsigned cyc_n = 0;
  int unsigned rm_lat = 3;
  bit          rm_silent = 1'b0;
  bit          rm_rand_stall = 1'b0;

  initial begin
    wbm.ack   = 1'b0;
    wbm.err   = 1'b0;
    wbm.dat_r = '0;
    wbm.stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      wbm.stall = rm_rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (!rm_silent && rm_q.size() > 0 && rm_q[0].due <= cyc_n) begin
        wbm.ack   = 1'b1;
        wbm.dat_r = rm_data(rm_q[0].adr);
      end else begin
        wbm.ack   = 1'b0;
        wbm.dat_r = '0;
      end
      @(negedge clk);
      #2;
      if (wbm.cyc !== 1'b1) begin
        rm_q.delete();
      end else begin
        if (wbm.ack) void'(rm_q.pop_front());
        if (wbm.stb === 1'b1 && !wbm.stall) rm_q.push_back('{wbm.adr, cyc_n + rm_lat + 1});
      end
    end
  end

  // Pipelined reads from the crossbar side; checks stall rule, ordering and data.
  task automatic run_reads(input int unsigned n, input bit gaps, output int unsigned peak);
    logic [31:0] exp_q[$];
    logic [31:0] exp_d;
    int unsigned issued, acked, tb_out, cycles;
    logic exp_stall;
    issued = 0; acked = 0; tb_out = 0; peak = 0; cycles = 0;
    while (acked < n && cycles < 400) begin
      @(negedge clk);
      cycles++;
      wbs.cyc   = 1'b1;
      wbs.we    = 1'b0;
      wbs.sel   = 4'hF;
      wbs.stb   = (issued < n) && !(gaps && $urandom_range(0, 2) == 0);
      wbs.adr   = ADDR_W'($urandom);
      #1;
      exp_stall = wbm.stall | (tb_out == MAXO);
      n_tests++;
      if (wbs.stall !== exp_stall) begin
        n_fail++;
        $display("FAIL run_stall: got %b expected %b (outstanding %0d)", wbs.stall, exp_stall, tb_out);
      end
      if (wbs.ack === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL run_spurious_ack: got ack expected none");
        end else begin
          exp_d = exp_q.pop_front();
          if (wbs.dat_r !== exp_d) begin
            n_fail++;
            $display("FAIL run_data: got %h expected %h", wbs.dat_r, exp_d);
          end
        end
        acked++;
        if (tb_out > 0) tb_out--;
      end
      if (wbs.stb && wbs.stall === 1'b0) begin
        exp_q.push_back(rm_data(wbs.adr));
        issued++;
        tb_out++;
      end
      if (tb_out > peak) peak = tb_out;
    end
    @(negedge clk);
    wbs.cyc = 1'b0;
    wbs.stb = 1'b0;
    n_tests++;
    if (acked != n) begin
      n_fail++;
      $display("FAIL run_count: got %0d acks expected %0d", acked, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rm_irq_i = 1'b1;
    #1;
    n_tests++;
    if (rm_shutdown_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", rm_shutdown_ack); end
    n_tests++;
    if (wbs.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", wbs.stall); end
    n_tests++;
    if (wbm.cyc !== 1'b0) begin n_fail++; $display("FAIL reset_wbm_cyc: got %b expected 0", wbm.cyc); end
    n_tests++;
    if (rm_irq_o !== 1'b1) begin n_fail++; $display("FAIL run_irq: got %b expected 1", rm_irq_o); end
`ifdef WB_RM_DECOUPLER_TIMEOUT_EN
    n_tests++;
    if (drain_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_flag: got %b expected 0", drain_timeout); end
`endif
    rm_irq_i = 1'b0;
  endtask

  task automatic test_passthrough;
    int unsigned peak;
    rm_silent = 1'b0; rm_rand_stall = 1'b0; rm_lat = 3;
    run_reads(8, 1'b0, peak);
    n_tests++;
    if (peak != MAXO) begin n_fail++; $display("FAIL pass_peak: got %0d expected %0d", peak, MAXO); end
  endtask

  task automatic test_random;
    int unsigned peak;
    for (int r = 0; r < 4; r++) begin
      rm_silent = 1'b0; rm_rand_stall = 1'b1; rm_lat = $urandom_range(0, 6);
      run_reads($urandom_range(10, 20), 1'b1, peak);
      n_tests++;
      if (peak > MAXO) begin n_fail++; $display("FAIL rand_peak: got %0d expected <= %0d", peak, MAXO); end
    end
    rm_rand_stall = 1'b0;
  endtask

  task automatic test_abort;
    int unsigned peak;
    rm_silent = 1'b1; rm_rand_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = 1'b0; wbs.adr = ADDR_W'($urandom);
    end
    @(negedge clk);
    wbs.cyc = 1'b0; wbs.stb = 1'b0;
    rm_silent = 1'b0; rm_lat = 3;
    run_reads(8, 1'b0, peak);
    n_tests++;
    if (peak != MAXO) begin n_fail++; $display("FAIL abort_peak: got %0d expected %0d", peak, MAXO); end
  endtask

  // Fill n_out requests, then quiesce; keep pushing a new request that must stay stalled.
  task automatic test_shutdown(input int unsigned n_out, input bit via_req);
    logic [31:0] exp_q[$];
    logic [31:0] exp_d;
    int unsigned issued, acked, post, stb_leak, stall_bad;
    bit req_on, done, exp_ack;
    issued = 0; acked = 0; post = 0; stb_leak = 0; stall_bad = 0;
    req_on = 1'b0; done = 1'b0;
    rm_silent = 1'b0; rm_rand_stall = 1'b0; rm_lat = 5;
    for (int j = 0; j < 60 && post < 4; j++) begin
      @(negedge clk);
      exp_ack   = via_req && done;
      wbs.cyc   = 1'b1;
      wbs.we    = 1'b0;
      wbs.adr   = ADDR_W'($urandom);
      if (issued < n_out) begin
        wbs.stb = 1'b1;
      end else if (!req_on) begin
        wbs.stb = 1'b0;
        req_on  = 1'b1;
        if (via_req) rm_shutdown_req = 1'b1; else rm_decouple = 1'b1;
      end else begin
        wbs.stb = !done;
      end
      #1;
      if (req_on && issued == n_out && wbs.stb) begin
        if (wbm.stb !== 1'b0) stb_leak++;
        if (wbs.stall !== 1'b1) stall_bad++;
      end
      if (wbs.ack === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL drain_spurious_ack: got ack expected none");
        end else begin
          exp_d = exp_q.pop_front();
          if (wbs.dat_r !== exp_d) begin
            n_fail++;
            $display("FAIL drain_data: got %h expected %h", wbs.dat_r, exp_d);
          end
        end
        acked++;
      end
      n_tests++;
      if (rm_shutdown_ack !== exp_ack) begin
        n_fail++;
        $display("FAIL shutdown_ack: got %b expected %b (acks seen %0d)", rm_shutdown_ack, exp_ack, acked);
      end
      if (!req_on && wbs.stb && wbs.stall === 1'b0) begin
        exp_q.push_back(rm_data(wbs.adr));
        issued++;
      end
      if (done) post++;
      if (req_on && acked == n_out) done = 1'b1;
    end
    @(negedge clk);
    wbs.stb = 1'b0;
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL drain_timeout_wait: got %0d acks expected %0d", acked, n_out); end
    n_tests++;
    if (stb_leak != 0) begin n_fail++; $display("FAIL drain_wbm_stb: got %0d forwarded expected 0", stb_leak); end
    n_tests++;
    if (stall_bad != 0) begin n_fail++; $display("FAIL drain_stall: got %0d unstalled cycles expected 0", stall_bad); end
  endtask

  task automatic test_isolated(input bit ack_exp);
    bit prev_stb;
    rm_irq_i = 1'b1;
    @(negedge clk);
    wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = 1'b1; wbs.sel = 4'hF;
    wbs.adr = ADDR_W'(28'h0000010); wbs.dat_w = 32'hDEADBEEF;
    #1;
    n_tests++;
    if (wbs.err !== 1'b0 || wbs.stall !== 1'b0) begin
      n_fail++; $display("FAIL iso_first: got err=%b stall=%b expected err=0 stall=0", wbs.err, wbs.stall);
    end
    n_tests++;
    if (wbm.cyc !== 1'b0 || wbm.stb !== 1'b0) begin
      n_fail++; $display("FAIL iso_wbm: got cyc=%b stb=%b expected 0 0", wbm.cyc, wbm.stb);
    end
    n_tests++;
    if (rm_irq_o !== 1'b0) begin n_fail++; $display("FAIL iso_irq: got %b expected 0", rm_irq_o); end
    @(negedge clk);
    wbs.stb = 1'b0;
    #1;
    n_tests++;
    if (wbs.err !== 1'b1 || wbs.ack !== 1'b0 || wbs.dat_r !== 32'h0) begin
      n_fail++; $display("FAIL iso_err: got err=%b ack=%b dat=%h expected 1 0 0", wbs.err, wbs.ack, wbs.dat_r);
    end
    n_tests++;
    if (rm_shutdown_ack !== ack_exp) begin n_fail++; $display("FAIL iso_ack: got %b expected %b", rm_shutdown_ack, ack_exp); end
    prev_stb = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      wbs.stb = (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
      wbs.adr = ADDR_W'($urandom);
      #1;
      n_tests++;
      if (wbs.err !== prev_stb || wbs.ack !== 1'b0 || wbm.cyc !== 1'b0) begin
        n_fail++;
        $display("FAIL iso_err_seq: got err=%b ack=%b wbm_cyc=%b expected err=%b 0 0", wbs.err, wbs.ack, wbm.cyc, prev_stb);
      end
      prev_stb = wbs.stb;
    end
    rm_irq_i = 1'b0;
  endtask

  task automatic test_release(input bit ack_before);
    int unsigned peak;
    @(negedge clk);
    wbs.cyc = 1'b0; wbs.stb = 1'b0;
    rm_shutdown_req = 1'b0; rm_decouple = 1'b0;
    #1;
    n_tests++;
    if (rm_shutdown_ack !== ack_before) begin n_fail++; $display("FAIL rel_ack_hold: got %b expected %b", rm_shutdown_ack, ack_before); end
    @(negedge clk);
    #1;
    n_tests++;
    if (rm_shutdown_ack !== 1'b0) begin n_fail++; $display("FAIL rel_ack_drop: got %b expected 0", rm_shutdown_ack); end
    rm_silent = 1'b0; rm_lat = 2;
    run_reads(2, 1'b0, peak);
  endtask

`ifdef WB_RM_DECOUPLER_TIMEOUT_EN
  task automatic test_timeout;
    bit exp_err, exp_ack, exp_flag;
    rm_silent = 1'b1; rm_rand_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = 1'b0; wbs.adr = ADDR_W'($urandom);
    end
    for (int j = 0; j < 23; j++) begin
      @(negedge clk);
      wbs.stb = 1'b0;
      rm_shutdown_req = 1'b1;
      #1;
      exp_err  = (j == 17 || j == 18);
      exp_ack  = (j >= 19);
      exp_flag = (j >= 17);
      n_tests++;
      if (wbs.err !== exp_err || rm_shutdown_ack !== exp_ack || drain_timeout !== exp_flag) begin
        n_fail++;
        $display("FAIL timeout_seq cycle %0d: got err=%b ack=%b flag=%b expected %b %b %b",
                 j, wbs.err, rm_shutdown_ack, drain_timeout, exp_err, exp_ack, exp_flag);
      end
    end
    rm_silent = 1'b0;
  endtask
`endif

  task automatic test_rst;
    int unsigned peak;
    rm_silent = 1'b1; rm_rand_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = 1'b0; wbs.adr = ADDR_W'($urandom);
    end
    @(negedge clk);
    wbs.stb = 1'b0; rm_shutdown_req = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (wbm.cyc !== 1'b1) begin n_fail++; $display("FAIL rst_drain_cyc: got %b expected 1", wbm.cyc); end
    @(negedge clk);
    rst = 1'b1; wbs.cyc = 1'b0; rm_shutdown_req = 1'b0;
    #1;
    n_tests++;
    if (wbm.cyc !== 1'b0) begin n_fail++; $display("FAIL rst_abandon: got wbm_cyc=%b expected 0", wbm.cyc); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (wbm.cyc !== 1'b0 || rm_shutdown_ack !== 1'b0 || wbs.stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_after: got cyc=%b ack=%b stall=%b expected 0 0 0", wbm.cyc, rm_shutdown_ack, wbs.stall);
    end
`ifdef WB_RM_DECOUPLER_TIMEOUT_EN
    n_tests++;
    if (drain_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_flag: got %b expected 0", drain_timeout); end
`endif
    rm_silent = 1'b0; rm_lat = 3;
    run_reads(8, 1'b0, peak);
    n_tests++;
    if (peak != MAXO) begin n_fail++; $display("FAIL rst_peak: got %0d expected %0d", peak, MAXO); end
  endtask

  initial begin
    rst = 1'b1; rm_shutdown_req = 1'b0; rm_decouple = 1'b0; rm_irq_i = 1'b0;
    wbs.adr = '0; wbs.dat_w = '0; wbs.sel = '0; wbs.we = 1'b0; wbs.cyc = 1'b0; wbs.stb = 1'b0;
    test_reset();
    test_passthrough();
    test_random();
    test_abort();
    test_shutdown(3, 1'b1);
    test_isolated(1'b1);
    test_release(1'b1);
    test_shutdown(4, 1'b0);
    test_isolated(1'b0);
    test_release(1'b0);
`ifdef WB_RM_DECOUPLER_TIMEOUT_EN
    test_timeout();
    test_release(1'b1);
`endif
    test_rst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
